// File: rtl/gpio_ctrl_chain.sv
// gpio_ctrl_chain: NCH-channel GPIO pad control with one shared serial
// configuration chain segment, frame-length checking and config readback.
module gpio_ctrl_chain #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned PAD_CTRL_BITS = 13,
  parameter int unsigned CHAIN_BITS    = NCH * PAD_CTRL_BITS,
  parameter int unsigned CNT_W         = $clog2(CHAIN_BITS + 2)
) (
  input  logic                    serial_clock,
  input  logic                    resetn,
  output logic                    serial_clock_out,
  output logic                    resetn_out,
  output logic                    serial_load_out,
  input  logic                    serial_load,
  input  logic                    serial_readback,
  input  logic                    serial_data_in,
  output logic                    serial_data_out,
  input  logic [CHAIN_BITS-1:0]   gpio_defaults,
  output logic                    cfg_error,
  output logic [7:0]              load_count,
  input  logic [NCH-1:0]          mgmt_gpio_out,
  input  logic [NCH-1:0]          mgmt_gpio_oeb,
  output logic [NCH-1:0]          mgmt_gpio_in,
  input  logic [NCH-1:0]          user_gpio_out,
  input  logic [NCH-1:0]          user_gpio_oeb,
  output logic [NCH-1:0]          user_gpio_in,
  input  logic                    user_power_good,
  output logic [NCH-1:0]          pad_gpio_holdover,
  output logic [NCH-1:0]          pad_gpio_slow_sel,
  output logic [NCH-1:0]          pad_gpio_vtrip_sel,
  output logic [NCH-1:0]          pad_gpio_inenb,
  output logic [NCH-1:0]          pad_gpio_ib_mode_sel,
  output logic [NCH-1:0]          pad_gpio_ana_en,
  output logic [NCH-1:0]          pad_gpio_ana_sel,
  output logic [NCH-1:0]          pad_gpio_ana_pol,
  output logic [NCH-1:0]          pad_gpio_outenb,
  output logic [NCH-1:0]          pad_gpio_out,
  output logic [3*NCH-1:0]        pad_gpio_dm,
  input  logic [NCH-1:0]          pad_gpio_in
);

  // Field offsets inside one channel word
  localparam int unsigned F_MGMT_EN = 0;
  localparam int unsigned F_OEB     = 1;
  localparam int unsigned F_HLDH    = 2;
  localparam int unsigned F_INP_DIS = 3;
  localparam int unsigned F_MOD_SEL = 4;
  localparam int unsigned F_AN_EN   = 5;
  localparam int unsigned F_AN_SEL  = 6;
  localparam int unsigned F_AN_POL  = 7;
  localparam int unsigned F_SLOW    = 8;
  localparam int unsigned F_TRIP    = 9;
  localparam int unsigned F_DM      = 10;
  localparam int unsigned DM_W      = 3;
  localparam int unsigned LCNT_W    = 8;

  // Bit-count values: exact frame length, and the saturation ceiling
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_BITS + 1);

  logic [CHAIN_BITS-1:0] shift_q;
  logic [CHAIN_BITS-1:0] shift_d;
  logic [CHAIN_BITS-1:0] cfg_q;
  logic [CHAIN_BITS-1:0] cfg_d;
  logic [CHAIN_BITS-1:0] cfg;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  load_q;
  logic                  load_edge;
  logic                  err_d;
  logic [LCNT_W-1:0]     lcnt_d;

  // Chain rebuffering towards the next instance
  assign serial_clock_out = serial_clock;
  assign resetn_out       = resetn;
  assign serial_load_out  = serial_load;

  // Live defaults drive the pads for as long as reset is held
  assign cfg       = resetn ? cfg_q : gpio_defaults;
  assign load_edge = serial_load & ~load_q;

  // Next-state decode: load edge, load hold, readback, then shift
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    err_d   = cfg_error;
    lcnt_d  = load_count;
    if (load_edge) begin
      cnt_d = '0;
      if (cnt_q == CNT_FULL) begin
        cfg_d  = shift_q;
        err_d  = 1'b0;
        lcnt_d = load_count + LCNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (!serial_load) begin
      if (serial_readback) begin
        shift_d = cfg_q;
        cnt_d   = '0;
      end else begin
        shift_d = {shift_q[CHAIN_BITS-2:0], serial_data_in};
        if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Chain state registers
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      load_q     <= 1'b0;
      cfg_error  <= 1'b0;
      load_count <= '0;
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      load_q     <= serial_load;
      cfg_error  <= err_d;
      load_count <= lcnt_d;
    end
  end

  // Committed configuration, returns to the defaults on reset
  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      cfg_q <= gpio_defaults;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  // Chain output retimed to the falling edge for hold margin downstream
  always_ff @(negedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      serial_data_out <= 1'b0;
    end else begin
      serial_data_out <= shift_q[CHAIN_BITS-1];
    end
  end

  assign mgmt_gpio_in = pad_gpio_in;
  assign user_gpio_in = pad_gpio_in & {NCH{user_power_good}};

  for (genvar k = 0; k < int'(NCH); k++) begin : g_ch
    logic [PAD_CTRL_BITS-1:0] word;
    logic [DM_W-1:0]          dm;
    logic                     out_c;
    logic                     oeb_c;

    assign word = cfg[k*PAD_CTRL_BITS +: PAD_CTRL_BITS];
    assign dm   = word[F_DM +: DM_W];

    assign pad_gpio_holdover[k]    = word[F_HLDH];
    assign pad_gpio_inenb[k]       = word[F_INP_DIS];
    assign pad_gpio_ib_mode_sel[k] = word[F_MOD_SEL];
    assign pad_gpio_ana_en[k]      = word[F_AN_EN];
    assign pad_gpio_ana_sel[k]     = word[F_AN_SEL];
    assign pad_gpio_ana_pol[k]     = word[F_AN_POL];
    assign pad_gpio_slow_sel[k]    = word[F_SLOW];
    assign pad_gpio_vtrip_sel[k]   = word[F_TRIP];
    assign pad_gpio_dm[DM_W*k +: DM_W] = dm;

    // Output/enable mux; pull modes drive the pull level when mgmt owns the pad as input
    always_comb begin
      out_c = user_gpio_out[k];
      oeb_c = user_gpio_oeb[k];
      if (word[F_MGMT_EN]) begin
        if (mgmt_gpio_oeb[k]) begin
          oeb_c = word[F_OEB];
          out_c = (dm[2:1] == 2'b01) ? ~dm[0] : mgmt_gpio_out[k];
        end else begin
          oeb_c = 1'b0;
          out_c = mgmt_gpio_out[k];
        end
      end
    end

    assign pad_gpio_out[k]    = out_c;
    assign pad_gpio_outenb[k] = oeb_c;
  end

endmodule
